// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line input and received-byte outputs of the 8N1 receiver
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
    modport master (output rx_in, input rx_data, rx_valid, frame_err, rx_busy);
    modport slave  (input rx_in, output rx_data, rx_valid, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver with mid-bit sampling and start/stop validation
module uart_rx #(
    parameter int BAUD_CNT_MAX = 56,
    parameter int HALF_CNT     = BAUD_CNT_MAX / 2
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
    localparam logic [13:0] C_BAUD_LAST = 14'(BAUD_CNT_MAX - 1);
    localparam logic [13:0] C_HALF_LAST = 14'(HALF_CNT - 1);
    state_t      r_state;
    logic        r_sync;
    logic        r_rx_s;
    logic        r_rx_d;
    logic [13:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        w_fall;
    logic        w_baud_last;
    assign w_fall      = r_rx_d & ~r_rx_s;
    assign w_baud_last = (r_baud_cnt == C_BAUD_LAST);
    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.rx_busy   = (r_state != IDLE);
    // line synchronizer and receive FSM; strobes default low so they last one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_d     <= 1'b1;
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_sync  <= bus.rx_in;
            r_rx_s  <= r_sync;
            r_rx_d  <= r_rx_s;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= '0;
                    if (w_fall) r_state <= START;
                end
                START: begin
                    if (r_baud_cnt == C_HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= r_rx_s ? IDLE : DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 14'd1;
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 14'd1;
                    end
                end
                STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (r_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= WAIT_HI;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 14'd1;
                    end
                end
                WAIT_HI: begin
                    r_baud_cnt <= '0;
                    if (r_rx_s) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a byte-level frame model
module tb_uart_rx;
    localparam int BAUD = 56;
    localparam int LAT  = 2 + BAUD / 2 + 9 * BAUD;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    logic [7:0] got_q[$];
    int         got_t[$];
    uart_rx_if bus();
    uart_rx #(.BAUD_CNT_MAX(BAUD)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // monitor: log every output event with its cycle stamp, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (bus.rx_valid) begin
                got_q.push_back(bus.rx_data);
                got_t.push_back(cyc);
            end
            if (bus.frame_err) ferr_cnt++;
            if (bus.rx_busy) busy_cnt++;
            if (bus.rx_valid && bus.frame_err) both_cnt++;
        end
    end
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
        bus.rx_in = 1'b0;
        wait_cyc(per);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = b[i];
            wait_cyc(per);
        end
        bus.rx_in = stop;
        wait_cyc(per);
    endtask
    task automatic test_reset;
        bus.rx_in = 1'b1;
        reset = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);
        checks++;
        if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.rx_data); end
        checks++;
        if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rx_valid); end
        checks++;
        if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
        checks++;
        if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.rx_busy); end
    endtask
    task automatic test_basic;
        int base, f0, t0;
        base = got_q.size();
        f0 = ferr_cnt;
        t0 = cyc;
        send_frame(8'hA5, BAUD, 1'b1);
        wait_cyc(20);
        checks++;
        if (got_q.size() != base + 1) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=1", got_q.size() - base);
        end else begin
            checks++;
            if (got_q[base] !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", got_q[base]); end
            checks++;
            if (got_t[base] - t0 < LAT - 4 || got_t[base] - t0 > LAT + 4) begin
                failures++;
                $display("FAIL basic_latency got=%0d exp=%0d+-4", got_t[base] - t0, LAT);
            end
        end
        checks++;
        if (ferr_cnt != f0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt - f0); end
    endtask
    task automatic test_glitch;
        int base, f0, b0;
        base = got_q.size();
        f0 = ferr_cnt;
        b0 = busy_cnt;
        bus.rx_in = 1'b0;
        wait_cyc(10);
        bus.rx_in = 1'b1;
        wait_cyc(BAUD * 12);
        checks++;
        if (got_q.size() != base) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", got_q.size() - base); end
        checks++;
        if (ferr_cnt != f0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
        checks++;
        if (busy_cnt - b0 < 25 || busy_cnt - b0 > 32) begin
            failures++;
            $display("FAIL glitch_busy got=%0d exp=25..32", busy_cnt - b0);
        end
    endtask
    task automatic test_frame_error;
        int base, f0;
        logic [7:0] prior;
        base = got_q.size();
        f0 = ferr_cnt;
        prior = bus.rx_data;
        send_frame(8'h3C, BAUD, 1'b0);
        wait_cyc(300);
        checks++;
        if (ferr_cnt != f0 + 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
        checks++;
        if (got_q.size() != base) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", got_q.size() - base); end
        checks++;
        if (bus.rx_data !== prior) begin failures++; $display("FAIL ferr_hold got=%h exp=%h", bus.rx_data, prior); end
        checks++;
        if (bus.rx_busy !== 1'b1) begin failures++; $display("FAIL ferr_busy_low_line got=%b exp=1", bus.rx_busy); end
        bus.rx_in = 1'b1;
        wait_cyc(10);
        checks++;
        if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_release got=%b exp=0", bus.rx_busy); end
        send_frame(8'h3C, BAUD, 1'b1);
        wait_cyc(20);
        checks++;
        if (got_q.size() != base + 1) begin
            failures++;
            $display("FAIL ferr_recover_count got=%0d exp=1", got_q.size() - base);
        end else begin
            checks++;
            if (got_q[base] !== 8'h3C) begin failures++; $display("FAIL ferr_recover_data got=%h exp=3c", got_q[base]); end
        end
    endtask
    task automatic test_back_to_back;
        int base;
        logic [7:0] exp_b[3];
        exp_b = '{8'h00, 8'hFF, 8'h55};
        base = got_q.size();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], BAUD, 1'b1);
        wait_cyc(20);
        checks++;
        if (got_q.size() != base + 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", got_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[base + i] !== exp_b[i]) begin
                    failures++;
                    $display("FAIL b2b_data%0d got=%h exp=%h", i, got_q[base + i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (got_t[base + i] - got_t[base + i - 1] != 10 * BAUD) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, got_t[base + i] - got_t[base + i - 1], 10 * BAUD);
                end
            end
        end
    endtask
    task automatic test_reset_mid_frame;
        int base;
        logic [7:0] b;
        b = 8'h96;
        base = got_q.size();
        bus.rx_in = 1'b0;
        wait_cyc(BAUD);
        for (int i = 0; i < 4; i++) begin
            bus.rx_in = b[i];
            wait_cyc(BAUD);
        end
        bus.rx_in = b[4];
        wait_cyc(BAUD / 2);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        checks++;
        if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", bus.rx_data); end
        checks++;
        if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.rx_busy); end
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_strobes got=%b%b exp=00", bus.rx_valid, bus.frame_err);
        end
        bus.rx_in = 1'b1;
        wait_cyc(BAUD * 11);
        checks++;
        if (got_q.size() != base) begin failures++; $display("FAIL midrst_valid got=%0d exp=0", got_q.size() - base); end
        send_frame(b, BAUD, 1'b1);
        wait_cyc(20);
        checks++;
        if (got_q.size() != base + 1) begin
            failures++;
            $display("FAIL midrst_recover_count got=%0d exp=1", got_q.size() - base);
        end else begin
            checks++;
            if (got_q[base] !== b) begin failures++; $display("FAIL midrst_recover_data got=%h exp=96", got_q[base]); end
        end
    endtask
    task automatic test_baud_skew;
        int base, f0;
        int per[2];
        per = '{54, 58};
        for (int k = 0; k < 2; k++) begin
            base = got_q.size();
            f0 = ferr_cnt;
            send_frame(8'hC3, per[k], 1'b1);
            wait_cyc(20);
            checks++;
            if (got_q.size() != base + 1 || got_q[got_q.size() - 1] !== 8'hC3) begin
                failures++;
                $display("FAIL skew%0d_data count=%0d exp=1 byte c3", per[k], got_q.size() - base);
            end
            checks++;
            if (ferr_cnt != f0) begin failures++; $display("FAIL skew%0d_ferr got=%0d exp=0", per[k], ferr_cnt - f0); end
        end
    endtask
    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int base, f0;
        base = got_q.size();
        f0 = ferr_cnt;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, $urandom_range(55, 57), 1'b1);
            wait_cyc($urandom_range(0, 20));
        end
        wait_cyc(20);
        checks++;
        if (got_q.size() != base + exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - base, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[base + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_data%0d got=%h exp=%h", i, got_q[base + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (ferr_cnt != f0) begin failures++; $display("FAIL rand_ferr got=%0d exp=0", ferr_cnt - f0); end
    endtask
    initial begin
        bus.rx_in = 1'b1;
        test_reset;
        test_basic;
        test_glitch;
        test_frame_error;
        test_back_to_back;
        test_reset_mid_frame;
        test_baud_skew;
        test_random;
        checks++;
        if (both_cnt != 0) begin failures++; $display("FAIL valid_and_ferr_together got=%0d exp=0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
